// File: rtl/gate_meas_ctrl_if.sv
// gate_meas_ctrl_if: host-side bus of the gate measurement sequencer.
// The host (master) issues start/abort/gate_len, supplies sig_in and
// result_ready; the sequencer (slave) returns status and the result pair.
interface gate_meas_ctrl_if #(
    parameter int CNT_W  = 32,
    parameter int GATE_W = 32
);
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_len;
    logic              sig_in;
    logic              busy;
    logic              gate_out;
    logic [CNT_W-1:0]  ref_cnt;
    logic [CNT_W-1:0]  sig_cnt;
    logic              overflow;
    logic              timeout;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output start, abort, gate_len, sig_in, result_ready,
        input  busy, gate_out, ref_cnt, sig_cnt, overflow, timeout, result_valid
    );

    modport slave (
        input  start, abort, gate_len, sig_in, result_ready,
        output busy, gate_out, ref_cnt, sig_cnt, overflow, timeout, result_valid
    );
endinterface

// File: rtl/gate_meas_ctrl.sv
// gate_meas_ctrl: sequencer for reciprocal (equal-precision) frequency
// measurement. Opens the gate on a sig_in rising edge, keeps it open for at
// least gate_len clocks, closes it on the next sig_in rising edge, and hands
// the (ref_cnt, sig_cnt) pair to the host over a valid/ready handshake.
// Host computes f_sig = f_clk * sig_cnt / ref_cnt.
// Optional feature: define GATE_TIMEOUT_EN to add a watchdog that ends a
// measurement stuck in ARM or CLOSE after TIMEOUT_CYC edge-free clocks.
module gate_meas_ctrl #(
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 32,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic sys_count_clk,
    input  logic rst,
    gate_meas_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE,
        ST_CLOSE,
        ST_DONE
    } state_t;

    state_t            state_q, state_n;
    logic [GATE_W-1:0] timer_q, timer_n;
    logic [CNT_W-1:0]  ref_w_q, ref_w_n;
    logic [CNT_W-1:0]  sig_w_q, sig_w_n;
    logic [CNT_W-1:0]  ref_res_q, ref_res_n;
    logic [CNT_W-1:0]  sig_res_q, sig_res_n;
    logic              ovf_q, ovf_n;

    // sig_in synchronizer and edge detector stages
    logic sync1_q, sync2_q, sync3_q, sig_edge;

`ifdef GATE_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q, wd_n;
    logic            to_q, to_n;
`endif

    // Saturating increment: the working counters stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchronizer on sig_in, then a registered rising-edge pulse.
    always_ff @(posedge sys_count_clk) begin
        // NOTE: all clocked state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            sig_edge <= 1'b0;
        end else begin
            sync1_q  <= bus.sig_in;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            sig_edge <= sync2_q & ~sync3_q;
        end
    end

    // Next-state and datapath update for the measurement sequence.
    always_comb begin
        // NOTE: every value written here gets its hold default first, so no
        // path through the case leaves it unassigned and no latch is inferred.
        state_n   = state_q;
        timer_n   = timer_q;
        ref_w_n   = ref_w_q;
        sig_w_n   = sig_w_q;
        ref_res_n = ref_res_q;
        sig_res_n = sig_res_q;
        ovf_n     = ovf_q;
`ifdef GATE_TIMEOUT_EN
        wd_n      = wd_q;
        to_n      = to_q;
`endif
        if (bus.abort) begin
            // Abort beats everything, including start and the DONE handshake;
            // result registers keep whatever they last held.
            state_n = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_n = ST_ARM;
                        timer_n = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
                        ref_w_n = '0;
                        sig_w_n = '0;
                        ovf_n   = 1'b0;
`ifdef GATE_TIMEOUT_EN
                        to_n    = 1'b0;
`endif
                    end
                end
                ST_ARM: begin
                    // The opening edge only starts the gate; it is not counted.
                    if (sig_edge) begin
                        state_n = ST_GATE;
                    end
`ifdef GATE_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        state_n   = ST_DONE;
                        to_n      = 1'b1;
                        ref_res_n = '0;
                        sig_res_n = '0;
                    end else begin
                        wd_n = wd_q + WD_W'(1);
                    end
`endif
                end
                ST_GATE: begin
                    if (&ref_w_q) ovf_n = 1'b1;
                    ref_w_n = sat_inc(ref_w_q);
                    if (sig_edge) begin
                        if (&sig_w_q) ovf_n = 1'b1;
                        sig_w_n = sat_inc(sig_w_q);
                    end
                    timer_n = timer_q - GATE_W'(1);
                    if (timer_q == GATE_W'(1)) begin
                        state_n = ST_CLOSE;
                    end
                end
                ST_CLOSE: begin
                    if (&ref_w_q) ovf_n = 1'b1;
                    ref_w_n = sat_inc(ref_w_q);
                    if (sig_edge) begin
                        // Closing edge completes the last whole period.
                        if (&sig_w_q) ovf_n = 1'b1;
                        sig_w_n   = sat_inc(sig_w_q);
                        state_n   = ST_DONE;
                        ref_res_n = ref_w_n;
                        sig_res_n = sig_w_n;
                    end
`ifdef GATE_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        state_n   = ST_DONE;
                        to_n      = 1'b1;
                        ref_res_n = ref_w_n;
                        sig_res_n = sig_w_n;
                    end else begin
                        wd_n = wd_q + WD_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    // Start is ignored here, even in the handshake cycle.
                    if (bus.result_ready) begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
`ifdef GATE_TIMEOUT_EN
        // Watchdog restarts on every state change (edges in ARM/CLOSE always
        // cause one).
        if (state_n != state_q) begin
            wd_n = '0;
        end
`endif
    end

    // State, working counters and result registers.
    always_ff @(posedge sys_count_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ref_w_q   <= '0;
            sig_w_q   <= '0;
            ref_res_q <= '0;
            sig_res_q <= '0;
            ovf_q     <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            wd_q      <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            ref_w_q   <= ref_w_n;
            sig_w_q   <= sig_w_n;
            ref_res_q <= ref_res_n;
            sig_res_q <= sig_res_n;
            ovf_q     <= ovf_n;
`ifdef GATE_TIMEOUT_EN
            wd_q      <= wd_n;
            to_q      <= to_n;
`endif
        end
    end

    // Status outputs are decodes of the state register.
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.gate_out     = (state_q == ST_GATE) || (state_q == ST_CLOSE);
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.ref_cnt      = ref_res_q;
    assign bus.sig_cnt      = sig_res_q;
    assign bus.overflow     = ovf_q;
`ifdef GATE_TIMEOUT_EN
    assign bus.timeout      = to_q;
`else
    assign bus.timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_gate_meas_ctrl.sv
// tb_gate_meas_ctrl: directed bench for gate_meas_ctrl. Three instances share
// one stimulus: a 32-bit build, an 8-bit build for saturation, and a
// short-timeout build for the watchdog (GATE_TIMEOUT_EN).
module tb_gate_meas_ctrl;

    logic        sys_count_clk = 1'b0;
    logic        rst           = 1'b1;
    logic        start         = 1'b0;
    logic        abort         = 1'b0;
    logic [31:0] gate_len      = 32'd0;
    logic        result_ready  = 1'b0;
    logic        sig_drv       = 1'b0;
    int          sig_period    = 10;
    int          ph            = 0;
    int          total         = 0;
    int          bad           = 0;

    gate_meas_ctrl_if #(.CNT_W(32), .GATE_W(32)) bus32 ();
    gate_meas_ctrl_if #(.CNT_W(8),  .GATE_W(32)) bus8 ();
    gate_meas_ctrl_if #(.CNT_W(32), .GATE_W(32)) bust ();

    assign bus32.start = start;  assign bus32.abort = abort;  assign bus32.gate_len = gate_len;
    assign bus32.sig_in = sig_drv;  assign bus32.result_ready = result_ready;
    assign bus8.start  = start;  assign bus8.abort  = abort;  assign bus8.gate_len  = gate_len;
    assign bus8.sig_in  = sig_drv;  assign bus8.result_ready  = result_ready;
    assign bust.start  = start;  assign bust.abort  = abort;  assign bust.gate_len  = gate_len;
    assign bust.sig_in  = sig_drv;  assign bust.result_ready  = result_ready;

    gate_meas_ctrl #(.CNT_W(32), .GATE_W(32), .TIMEOUT_CYC(1000)) dut32 (
        .sys_count_clk(sys_count_clk), .rst(rst), .bus(bus32));
    gate_meas_ctrl #(.CNT_W(8), .GATE_W(32), .TIMEOUT_CYC(1000)) dut8 (
        .sys_count_clk(sys_count_clk), .rst(rst), .bus(bus8));
    gate_meas_ctrl #(.CNT_W(32), .GATE_W(32), .TIMEOUT_CYC(50)) dutt (
        .sys_count_clk(sys_count_clk), .rst(rst), .bus(bust));

    always #5 sys_count_clk = ~sys_count_clk;

    // Periodic sig_in: one rising edge every sig_period clocks; 0 = stuck low.
    always @(posedge sys_count_clk) begin
        #2;
        if (sig_period == 0) begin
            ph      = 0;
            sig_drv = 1'b0;
        end else begin
            if (ph >= sig_period - 1) ph = 0;
            else                      ph = ph + 1;
            sig_drv = (ph < sig_period / 2);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_count_clk);
        #1;
    endtask

    task automatic set_period(input int p);
        sig_period = p;
        repeat (2 * p + 6) step();
    endtask

    task automatic pulse_start(input logic [31:0] len);
        gate_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_gate_open(input string tag, input int budget);
        int n = 0;
        while (!bus32.gate_out && n < budget) begin
            step();
            n++;
        end
        check(tag, bus32.gate_out, 1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus32.result_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, bus32.result_valid, 1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  stable_ok;

        // Reset state
        repeat (3) step();
        check("rst_busy",     bus32.busy, 0);
        check("rst_gate_out", bus32.gate_out, 0);
        check("rst_valid",    bus32.result_valid, 0);
        check("rst_counts",   {bus32.ref_cnt, bus32.sig_cnt}, 0);
        check("rst_flags",    {bus32.overflow, bus32.timeout}, 0);
        rst = 1'b0;

        // Period 10, gate_len 100: gate 110 clocks, ref 110, sig 11
        set_period(10);
        pulse_start(32'd100);
        check("t1_busy", bus32.busy, 1);
        wait_gate_open("t1_open", 40);
        n = 0;
        while (bus32.gate_out && n < 500) begin
            n++;
            step();
        end
        check("t1_gate_cycles", n, 110);
        check("t1_valid",  bus32.result_valid, 1);
        check("t1_ref",    bus32.ref_cnt, 110);
        check("t1_sig",    bus32.sig_cnt, 11);
        check("t1_ovf",    bus32.overflow, 0);
        check("t1_to",     bus32.timeout, 0);
        check("t1_ref8",   bus8.ref_cnt, 110);

        // Host stalls 20 clocks with stray starts; result must stay put
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = (i % 5 == 0);
            step();
            if (!(bus32.result_valid === 1'b1 && bus32.ref_cnt === 32'd110 &&
                  bus32.sig_cnt === 32'd11)) stable_ok = 1'b0;
        end
        check("t1_hold_stable", stable_ok, 1);
        // Start coinciding with the handshake is ignored
        start        = 1'b1;
        result_ready = 1'b1;
        step();
        start        = 1'b0;
        result_ready = 1'b0;
        check("t1_hs_valid", bus32.result_valid, 0);
        check("t1_hs_idle",  bus32.busy, 0);
        check("t1_ref_held", bus32.ref_cnt, 110);

        // Period 7, gate_len 0 treated as 1: ref 7, sig 1
        set_period(7);
        pulse_start(32'd0);
        wait_valid("t2_valid", 100);
        check("t2_ref", bus32.ref_cnt, 7);
        check("t2_sig", bus32.sig_cnt, 1);
        handshake();

        // Period 300, gate_len 10: 8-bit build saturates, 32-bit does not
        set_period(300);
        pulse_start(32'd10);
        wait_valid("t3_valid", 700);
        check("t3_valid8", bus8.result_valid, 1);
        check("t3_ref8",   bus8.ref_cnt, 255);
        check("t3_sig8",   bus8.sig_cnt, 1);
        check("t3_ovf8",   bus8.overflow, 1);
        check("t3_ref32",  bus32.ref_cnt, 300);
        check("t3_ovf32",  bus32.overflow, 0);
        handshake();
        check("t3_ovf8_sticky", bus8.overflow, 1);

        // Abort in GATE: idle next cycle, no result, prior result kept
        set_period(10);
        pulse_start(32'd100);
        check("t4_ovf8_cleared", bus8.overflow, 0);
        wait_gate_open("t4_open", 40);
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_busy",     bus32.busy, 0);
        check("t4_gate_out", bus32.gate_out, 0);
        check("t4_valid",    bus32.result_valid, 0);
        check("t4_ref_kept", bus32.ref_cnt, 300);
        repeat (150) step();
        check("t4_no_result", {bus32.busy, bus32.result_valid}, 0);

        // Abort and start together from IDLE: abort wins
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("t5_abort_start", bus32.busy, 0);

        // Reset while in CLOSE clears every output
        pulse_start(32'd5);
        wait_gate_open("t6_open", 40);
        repeat (7) step();
        check("t6_in_close", bus32.gate_out, 1);
        rst = 1'b1;
        step();
        check("t6_busy",   bus32.busy, 0);
        check("t6_gate",   bus32.gate_out, 0);
        check("t6_valid",  bus32.result_valid, 0);
        check("t6_counts", {bus32.ref_cnt, bus32.sig_cnt}, 0);
        check("t6_flags",  {bus32.overflow, bus32.timeout}, 0);
        rst = 1'b0;

        // sig_in stuck low: watchdog ends ARM after 50 clocks, or ARM holds
        sig_period = 0;
        repeat (10) step();
        pulse_start(32'd10);
`ifdef GATE_TIMEOUT_EN
        n = 0;
        while (!bust.result_valid && n < 100) begin
            step();
            n++;
        end
        check("t7_to_latency", n, 50);
        check("t7_to_valid",   bust.result_valid, 1);
        check("t7_to_flag",    bust.timeout, 1);
        check("t7_to_counts",  {bust.ref_cnt, bust.sig_cnt}, 0);
        handshake();
        check("t7_to_idle",    bust.busy, 0);
`else
        repeat (60) step();
        check("t7_arm_busy",  bust.busy, 1);
        check("t7_arm_gate",  bust.gate_out, 0);
        check("t7_arm_valid", bust.result_valid, 0);
        check("t7_arm_to",    bust.timeout, 0);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t7_exit", bust.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
